// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, data width and line levels.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts system clocks and strobes bit_done on the last
// clock of every bit period, wrapping straight back to zero so periods never drift.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic bit_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_done = en && (cnt_q == CNT_MAX);

   // clr wins over en so a new frame always starts from a fresh period
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = bit_done ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter: one character per valid/ready handshake, shifted out
// LSB first with start and stop bits; all outputs are registered.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e state_q;
   logic        tx_q;
   logic        ready_q;
   logic        busy_q;
   logic [7:0]  shift_q;
   logic [2:0]  bitIdx_q;

   logic handshake;
   logic bitDone;

   assign handshake = tx_valid && ready_q;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (handshake),
      .en       (busy_q),
      .bit_done (bitDone)
   );

   // tx_q always holds the level for the state being entered, so the line
   // changes on the same edge as the state and each level lasts one full period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tx_q     <= IDLE_LEVEL;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         shift_q  <= '0;
         bitIdx_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  state_q  <= START;
                  tx_q     <= START_LEVEL;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  shift_q  <= tx_data;
                  bitIdx_q <= '0;
               end
            end
            START: begin
               if (bitDone) begin
                  state_q  <= DATA;
                  tx_q     <= shift_q[0];
                  bitIdx_q <= '0;
               end
            end
            DATA: begin
               if (bitDone) begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bitIdx_q == LAST_BIT) begin
                     state_q  <= STOP;
                     tx_q     <= STOP_LEVEL;
                     bitIdx_q <= '0;
                  end else begin
                     tx_q     <= shift_q[1];
                     bitIdx_q <= bitIdx_q + 3'd1;
                  end
               end
            end
            STOP: begin
               if (bitDone) begin
                  state_q <= IDLE;
                  tx_q    <= IDLE_LEVEL;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= IDLE_LEVEL;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte with 4 clocks per bit: a frame-level
// line model checked every cycle, plus literal frame and timing checks.
module tb_uart_tx_byte;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   int nCompared   = 0;
   int nMismatched = 0;

   uart_tx_byte #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line model: -1 means idle, otherwise the cycle number within the frame.
   int         mCycle = -1;
   logic [9:0] mFrame = '1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mCycle = -1;
      end else if (mCycle < 0) begin
         if (tx_valid) begin
            mFrame = {1'b1, tx_data, 1'b0};
            mCycle = 0;
         end
      end else if (mCycle == FRAME - 1) begin
         mCycle = -1;
      end else begin
         mCycle = mCycle + 1;
      end
   end

   always @(negedge clk) begin
      if (mCycle < 0) begin
         checkOutput("model tx", {31'd0, tx}, 32'd1);
         checkOutput("model tx_ready", {31'd0, tx_ready}, 32'd1);
         checkOutput("model busy", {31'd0, busy}, 32'd0);
      end else begin
         checkOutput("model tx", {31'd0, tx}, {31'd0, mFrame[mCycle / CPB]});
         checkOutput("model tx_ready", {31'd0, tx_ready}, 32'd0);
         checkOutput("model busy", {31'd0, busy}, 32'd1);
      end
   end

   // Every level change inside a frame lands on a bit boundary, and every
   // completed frame is exactly 40 busy cycles.
   int   busyRun  = 0;
   logic prevBusy = 1'b0;
   logic prevTx   = 1'b1;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyRun  = 0;
         prevBusy = 1'b0;
         prevTx   = 1'b1;
      end else begin
         if (busy) begin
            busyRun = busyRun + 1;
            if (prevBusy && (tx !== prevTx))
               checkOutput("bit width", (busyRun - 1) % CPB, 0);
         end else begin
            if (prevBusy)
               checkOutput("frame length", busyRun, FRAME);
            busyRun = 0;
         end
         prevBusy = busy;
         prevTx   = tx;
      end
   end

   // Handshake lands on the second rising edge; returns 2 time units after it.
   task automatic applyStimulus(input logic [7:0] data, input logic holdValid);
      @(posedge clk);
      #2;
      tx_valid = 1'b1;
      tx_data  = data;
      @(posedge clk);
      #2;
      if (!holdValid)
         tx_valid = 1'b0;
   endtask

   task automatic watchFrame(input int nCycles, output logic [9:0] bits, output int busyLen);
      bits    = '1;
      busyLen = 0;
      for (int k = 0; k < nCycles; k++) begin
         @(negedge clk);
         if (k < FRAME && (k % CPB) == 2)
            bits[k / CPB] = tx;
         if (busy)
            busyLen++;
      end
   endtask

   logic [9:0] bits1;
   logic [9:0] bits2;
   int         busyLen;

   initial begin
      // reset with tx_valid high: must not start a frame
      #1;
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      rst_n    = 1'b0;
      #1;
      checkOutput("reset tx", {31'd0, tx}, 32'd1);
      checkOutput("reset tx_ready", {31'd0, tx_ready}, 32'd1);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      tx_valid = 1'b0;
      rst_n    = 1'b1;

      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         checkOutput("idle levels", {29'd0, tx, tx_ready, busy}, 32'b110);
      end

      $display("[TB] single character 0x35");
      applyStimulus(8'h35, 1'b0);
      watchFrame(45, bits1, busyLen);
      checkOutput("frame 0x35 bits", {22'd0, bits1}, {22'd0, 10'b1001101010});
      checkOutput("frame 0x35 busy cycles", busyLen, 40);

      $display("[TB] back-to-back 0x30 then 0x39");
      applyStimulus(8'h30, 1'b1);
      tx_data = 8'h39;
      bits1 = '1;
      bits2 = '1;
      for (int k = 0; k < 81; k++) begin
         @(negedge clk);
         if (k < FRAME && (k % CPB) == 2)
            bits1[k / CPB] = tx;
         if (k == FRAME)
            checkOutput("gap levels", {29'd0, tx, tx_ready, busy}, 32'b110);
         if (k == FRAME + 1) begin
            checkOutput("second start at 41", {31'd0, tx}, 32'd0);
            tx_valid = 1'b0;
         end
         if (k > FRAME && ((k - FRAME - 1) % CPB) == 2)
            bits2[(k - FRAME - 1) / CPB] = tx;
      end
      checkOutput("frame 0x30 bits", {22'd0, bits1}, {22'd0, 10'b1001100000});
      checkOutput("frame 0x39 bits", {22'd0, bits2}, {22'd0, 10'b1001110010});
      repeat (5) @(negedge clk);

      $display("[TB] ignore while busy");
      applyStimulus(8'h31, 1'b0);
      bits1   = '1;
      busyLen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 12) begin
            tx_valid = 1'b1;
            tx_data  = 8'h23;
         end
         if (k == 13)
            tx_valid = 1'b0;
         if (k < FRAME && (k % CPB) == 2)
            bits1[k / CPB] = tx;
         if (k < FRAME && busy !== 1'b1)
            checkOutput("busy held", {31'd0, busy}, 32'd1);
         if (busy)
            busyLen++;
      end
      checkOutput("frame 0x31 bits", {22'd0, bits1}, {22'd0, 10'b1001100010});
      checkOutput("no extra frame", busyLen, 40);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h38, 1'b0);
      for (int k = 0; k < 18; k++)
         @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort tx", {31'd0, tx}, 32'd1);
      checkOutput("abort busy", {31'd0, busy}, 32'd0);
      checkOutput("abort tx_ready", {31'd0, tx_ready}, 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      applyStimulus(8'h32, 1'b0);
      watchFrame(45, bits1, busyLen);
      checkOutput("frame 0x32 bits", {22'd0, bits1}, {22'd0, 10'b1001100100});
      checkOutput("frame 0x32 busy cycles", busyLen, 40);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            #1;
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
         end
      end
      @(posedge clk);
      #2;
      tx_valid = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      checkOutput("final idle", {29'd0, tx, tx_ready, busy}, 32'b110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Serial transmitter that sits directly downstream of the BCD-digit-to-ASCII stage.
- Accepts one 8-bit character per valid/ready handshake and shifts it out as an asynchronous 8N1 frame on the UART TX line: start bit, 8 data bits LSB first, 1 stop bit.
- Line idles high.
- Bit timing is derived by counting system clocks; no separate baud clock exists.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200). Legal range >= 2.
- DATA_BITS, 8, data bits per frame. Fixed at 8; exposed only for the package constant.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- tx_data  input  8  character to send; sampled only on handshake.
- tx_valid  input  1  upstream has a character.
- tx_ready  output  1  block can accept a character this cycle.
- tx  output  1  serial line out, registered.
- busy  output  1  frame in progress (any state other than IDLE).

Interface decision (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: asserting rst_n low immediately forces the following, with no clock needed:
  - state = IDLE
  - tx = 1
  - tx_ready = 1
  - busy = 0
  - bit counter = 0, clock counter = 0
  - shift register = 0
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx = 1, tx_ready = 1.
  - Handshake occurs when tx_valid = 1 and tx_ready = 1 on a rising edge.
  - On handshake: latch tx_data into the shift register, clear the clock counter, go to START.
- START:
  - tx = 0 for exactly CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit period, shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency and frame timing:
  - Handshake at edge N puts tx = 0 from edge N onward (the registered output updates on that edge).
  - The full frame is 10*CLKS_PER_BIT cycles.
- Outputs in non-IDLE states: tx_ready = 0 and busy = 1 throughout START, DATA and STOP.
- tx_ready is a registered/state-decoded output and must not depend combinationally on tx_valid.
- Back-to-back frames:
  - After STOP ends, the block spends at least one cycle in IDLE with tx_ready = 1.
  - If tx_valid is held high, the next handshake occurs in that cycle.
  - The inter-frame gap is therefore exactly one extra high cycle beyond the stop bit.
- tx_valid or tx_data changes while busy: ignored. The in-flight frame is unaffected, no character is captured, and upstream must hold the character until tx_ready.
- tx_valid high during reset: ignored. First acceptance is possible on the first rising edge after rst_n deasserts.
- Reset mid-frame: the frame is aborted, tx goes high immediately, and the partial character is discarded.
- Clock counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1.
  - The bit-period-end strobe fires when count == CLKS_PER_BIT-1; the counter then wraps to 0.
  - No drift is allowed: each bit is exactly CLKS_PER_BIT cycles.
- Bit index: 3 bits. It wraps from 7 to 0 only on the DATA-to-STOP transition.
- No parity, no break generation, no flow-control inputs.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - DATA_BITS = 8
  - constants IDLE_LEVEL = 1'b1, START_LEVEL = 1'b0, STOP_LEVEL = 1'b1
  - These are reused by the future receiver.
- One sub-module: uart_baud_cnt.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst_n, clr, en.
  - Output: bit_done strobe.
  - Also reused by the receiver for mid-bit sampling.

Test Plan:
Bench uses CLKS_PER_BIT = 4, so one frame is 40 cycles. Line bits below are listed in transmission order (start, d0..d7, stop).
- Single char: tx_data = 8'h35 ('5') with a 1-cycle tx_valid. Expected:
  - tx sequence, each level held 4 cycles: 0, 1,0,1,0,1,1,0,0, 1.
  - busy high for 40 cycles; tx_ready low for the same 40 cycles.
- Back-to-back: tx_valid held high with 8'h30 ('0'), then 8'h39 ('9') presented on the second handshake. Expected:
  - Frame 1: 0, 0,0,0,0,1,1,0,0, 1.
  - One idle-high cycle with tx_ready = 1.
  - Frame 2: 0, 1,0,0,1,1,1,0,0, 1.
  - Second start bit begins 41 cycles after the first.
- Ignore while busy: during frame 8'h31, pulse tx_valid with 8'h23 at cycle 12. Expected: the frame is still 8'h31 bits, no second frame follows, and tx_ready remains low until the frame ends.
- Reset mid-frame: assert rst_n low at cycle 17 of frame 8'h38. Expected:
  - tx = 1, busy = 0, tx_ready = 1 immediately (asynchronous).
  - After release, sending 8'h32 produces a clean, correct 40-cycle frame.
- Idle and reset values: hold tx_valid = 0 for 100 cycles after reset. Expected: tx = 1, tx_ready = 1, busy = 0 throughout; a checker asserts the bit-width of every level is exactly 4 cycles in all tests.
